// File: rtl/fetch_buffer_if.sv
// Handshake bundle between I-cache fetch, the fetch buffer and the decoder.
// The buffer connects through the slave modport; the fetch/decode side uses master.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface fetch_buffer_if #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int DATA_WIDTH = `DATA_WIDTH
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  in_valid;
   logic [ADDR_WIDTH-1:0] in_pc;
   logic [DATA_WIDTH-1:0] in_inst;
   logic                  in_ready;
   logic                  flush;
   logic                  out_valid;
   logic [ADDR_WIDTH-1:0] out_pc;
   logic [DATA_WIDTH-1:0] out_inst;
   logic                  out_ready;
   logic [CW-1:0]         count;

   modport slave (
      input  in_valid, in_pc, in_inst, flush, out_ready,
      output in_ready, out_valid, out_pc, out_inst, count
   );

   modport master (
      output in_valid, in_pc, in_inst, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_inst, count
   );
endinterface

// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction queue holding {pc, inst} pairs; flush drops all entries.
// Optional FETCH_BUFFER_BYPASS_EN passes a push straight to the outputs when the queue is empty.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_buffer #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int DATA_WIDTH = `DATA_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   fetch_buffer_if.slave fb
);
   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;
   localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] inst;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          empty_s, full_s, bypass_s, valid_s;
   logic          push_s, pop_s, take_s;
   entry_t        head_s;

   // Occupancy flags, head selection and handshake qualification.
   always_comb begin
      empty_s = (wr_ptr_q == rd_ptr_q);
      full_s  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
`ifdef FETCH_BUFFER_BYPASS_EN
      bypass_s = empty_s & ~fb.flush & ~rst;
`else
      bypass_s = 1'b0;
`endif
      if (bypass_s) begin
         valid_s = fb.in_valid;
         head_s  = {fb.in_pc, fb.in_inst};
      end else begin
         valid_s = ~empty_s & ~rst;
         head_s  = mem_q[rd_ptr_q[IW-1:0]];
      end
`ifdef FETCH_BUFFER_BYPASS_EN
      valid_s = valid_s & ~fb.flush;
`endif
      push_s = fb.in_valid & ~full_s & ~rst;
      pop_s  = valid_s & fb.out_ready;
      // A bypassed entry consumed in the same cycle never touches storage.
      take_s = bypass_s & push_s & fb.out_ready;
   end

   // Decoder-facing outputs; data reads as zero whenever nothing is presented.
   always_comb begin
      fb.in_ready  = ~full_s & ~rst;
      fb.out_valid = valid_s;
      if (valid_s) begin
         fb.out_pc   = head_s.pc;
         fb.out_inst = head_s.inst;
      end else begin
         fb.out_pc   = {ADDR_WIDTH{1'b0}};
         fb.out_inst = {DATA_WIDTH{1'b0}};
      end
      if (rst) begin
         fb.count = PTR_ZERO;
      end else begin
         fb.count = wr_ptr_q - rd_ptr_q;
      end
   end

   // Pointer next-state: reset and flush win over push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (rst || fb.flush) begin
         wr_ptr_d = PTR_ZERO;
         rd_ptr_d = PTR_ZERO;
      end else if (take_s) begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
      end
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage; contents survive flush and reset on purpose.
   always_ff @(posedge clk) begin
      if (push_s && !fb.flush && !take_s) begin
         mem_q[wr_ptr_q[IW-1:0]] <= {fb.in_pc, fb.in_inst};
      end
   end
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based reference model plus directed scenarios.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_fetch_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = `ADDR_WIDTH;
   localparam int DW    = `DATA_WIDTH;
`ifdef FETCH_BUFFER_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   typedef struct {
      logic [AW-1:0] pc;
      logic [DW-1:0] inst;
   } ent_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic mdl_en;
   logic seen_200;
   ent_t q[$];

   fetch_buffer_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fbi ();

   fetch_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .fb  (fbi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected outputs from the queue contents and the current inputs.
   function automatic void model_out(output logic v, output logic [AW-1:0] pc,
                                     output logic [DW-1:0] inst, output logic rdy,
                                     output int cnt);
      v    = 1'b0;
      pc   = '0;
      inst = '0;
      rdy  = !rst && (q.size() < DEPTH);
      cnt  = rst ? 0 : q.size();
      if (!rst) begin
         if (q.size() > 0) begin
            v = 1'b1;
            pc = q[0].pc;
            inst = q[0].inst;
         end else if (BYP != 0 && fbi.in_valid) begin
            v = 1'b1;
            pc = fbi.in_pc;
            inst = fbi.in_inst;
         end
         if (BYP != 0 && fbi.flush) begin
            v = 1'b0;
            pc = '0;
            inst = '0;
         end
      end
   endfunction

   // Model state update at each rising edge.
   always @(posedge clk) begin
      logic v, rdy, push;
      logic [AW-1:0] pc;
      logic [DW-1:0] inst;
      int cnt;
      ent_t e;
      model_out(v, pc, inst, rdy, cnt);
      if (rst || fbi.flush) begin
         q.delete();
      end else begin
         push = fbi.in_valid && (q.size() < DEPTH);
         if (!(BYP != 0 && q.size() == 0 && push && fbi.out_ready)) begin
            if (v && fbi.out_ready) void'(q.pop_front());
            if (push) begin
               e.pc = fbi.in_pc;
               e.inst = fbi.in_inst;
               q.push_back(e);
            end
         end
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic v, rdy;
      logic [AW-1:0] pc;
      logic [DW-1:0] inst;
      int cnt;
      if (fbi.out_valid && fbi.out_pc == 32'h200) seen_200 = 1'b1;
      if (mdl_en) begin
         model_out(v, pc, inst, rdy, cnt);
         chk("in_ready", 64'(fbi.in_ready), 64'(rdy));
         chk("out_valid", 64'(fbi.out_valid), 64'(v));
         chk("out_pc", 64'(fbi.out_pc), 64'(pc));
         chk("out_inst", 64'(fbi.out_inst), 64'(inst));
         chk("count", 64'(fbi.count), 64'(cnt));
      end
   end

   task automatic cyc(input logic r, input logic f, input logic iv,
                      input logic [AW-1:0] pc, input logic ordy);
      @(posedge clk);
      #1;
      rst           = r;
      fbi.flush     = f;
      fbi.in_valid  = iv;
      fbi.in_pc     = pc;
      fbi.in_inst   = $urandom;
      fbi.out_ready = ordy;
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      mdl_en = 1'b0;
      seen_200 = 1'b0;
      rst = 1'b1;
      fbi.flush = 1'b0;
      fbi.in_valid = 1'b0;
      fbi.in_pc = '0;
      fbi.in_inst = '0;
      fbi.out_ready = 1'b0;
      @(posedge clk);
      mdl_en = 1'b1;

      // Reset held with in_valid asserted.
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 32'h50, 1'b0);
         chk("rst_in_ready", 64'(fbi.in_ready), 64'd0);
         chk("rst_out_valid", 64'(fbi.out_valid), 64'd0);
         chk("rst_count", 64'(fbi.count), 64'd0);
      end

      // Fill with out_ready low, then overflow attempt.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 1'b0);
         chk("fill_count", 64'(fbi.count), 64'(i));
      end
      cyc(1'b0, 1'b0, 1'b1, 32'h110, 1'b0);
      chk("full_count", 64'(fbi.count), 64'd4);
      chk("full_in_ready", 64'(fbi.in_ready), 64'd0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         chk("drain_pc", 64'(fbi.out_pc), 64'(32'h100 + 32'(4 * i)));
      end
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("drain_empty", 64'(fbi.count), 64'd0);

      // Streaming push+pop across several pointer wraps.
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 32'h1000 + 32'(4 * i), 1'b1);
         if (i > 0) chk("stream_count", 64'(fbi.count), 64'(BYP != 0 ? 0 : 1));
      end
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("stream_end", 64'(fbi.count), 64'd0);

      // Flush with a concurrent push of pc 0x200.
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 32'h500 + 32'(4 * i), 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
      chk("preflush_count", 64'(fbi.count), 64'd3);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("flush_valid", 64'(fbi.out_valid), 64'd0);
      chk("flush_count", 64'(fbi.count), 64'd0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("flush_no_200", 64'(seen_200), 64'd0);

      // Latency of a push into an empty buffer with decode ready.
      cyc(1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
      chk("lat0_valid", 64'(fbi.out_valid), 64'(BYP));
      if (BYP != 0) chk("lat0_pc", 64'(fbi.out_pc), 64'h300);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("lat1_valid", 64'(fbi.out_valid), 64'(1 - BYP));
      if (BYP == 0) chk("lat1_pc", 64'(fbi.out_pc), 64'h300);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("lat_count", 64'(fbi.count), 64'd0);

      // Reset pulse in the middle of a stream.
      cyc(1'b0, 1'b0, 1'b1, 32'h400, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'h404, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("midrst_count_pre", 64'(fbi.count), 64'd0);
      chk("midrst_in_ready", 64'(fbi.in_ready), 64'd0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         chk("midrst_valid", 64'(fbi.out_valid), 64'd0);
         chk("midrst_count", 64'(fbi.count), 64'd0);
      end

      // Randomized traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(63) == 0), ($urandom_range(31) == 0),
             ($urandom_range(99) < 60), AW'($urandom) & ~AW'(3),
             ($urandom_range(99) < 50));
      end

      mdl_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
